// File: rtl/rvv_alu_lanes.sv
// LANES-wide vector integer ALU sequencer: walks a whole vector register LANES
// elements per cycle, with vl tail handling and v0 masking (undisturbed policy).
module rvv_alu_lanes #(
    parameter int VLEN  = 128,
    parameter int LANES = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                opcode,
    input  logic [2:0]                op_type,
    input  logic [2:0]                vsew,
    input  logic [$clog2(VLEN/8):0]   vl,
    input  logic                      vm,
    input  logic [VLEN/8-1:0]         v0,
    input  logic [31:0]               rs1,
    input  logic [4:0]                imm,
    input  logic [VLEN-1:0]           vs1,
    input  logic [VLEN-1:0]           vs2,
    input  logic [VLEN-1:0]           vd_old,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [VLEN-1:0]           vd,
    output logic                      illegal,
    output logic [1:0]                dbg_state
);

    localparam int EW  = VLEN / 8;       // max element count (SEW8)
    localparam int EB  = $clog2(EW);     // element index width
    localparam int VLW = EB + 1;         // vl width
    localparam int IW  = VLW + 1;        // elem_i + LANES never overflows this

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    logic [2:0]      op_r;
    logic [1:0]      sew_r;
    logic            is_vv_r;
    logic            vm_r;
    logic [EW-1:0]   v0_r;
    logic [31:0]     scalar_r;
    logic [VLEN-1:0] vs1_r;
    logic [VLEN-1:0] vs2_r;
    logic [VLW-1:0]  eff_vl_r;
    logic [IW-1:0]   elem_i;

    // Both sides use valid/ready: a transfer happens on a rising edge where
    // valid and ready are both high; valid never drops before that edge.
    logic            accept;
    logic            req_illegal;
    logic [VLW-1:0]  vlmax_in;
    logic [VLW-1:0]  eff_vl_in;

    assign accept      = in_valid && in_ready;
    assign req_illegal = (vsew > 3'd2) || (opcode == 3'b111) ||
                         !((op_type == 3'b001) || (op_type == 3'b010) || (op_type == 3'b100));
    assign vlmax_in    = VLW'(EW >> vsew[1:0]);
    assign eff_vl_in   = (vl < vlmax_in) ? vl : vlmax_in;
    assign dbg_state   = state;

    function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
        // Operands arrive zero-extended from SEW, so 32-bit unsigned compares are exact.
        case (op)
            3'b000:  alu = a + b;
            3'b001:  alu = a - b;
            3'b010:  alu = a & b;
            3'b011:  alu = a | b;
            3'b100:  alu = a ^ b;
            3'b101:  alu = (a < b) ? a : b;
            3'b110:  alu = (a > b) ? a : b;
            default: alu = a;
        endcase
    endfunction

    logic [IW-1:0] lane_idx [LANES];
    logic [EB-1:0] lane_el  [LANES];
    logic [31:0]   lane_a   [LANES];
    logic [31:0]   lane_b   [LANES];
    logic [31:0]   lane_res [LANES];
    logic [LANES-1:0] lane_we;

    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            lane_idx[j] = elem_i + IW'(j);
            lane_el[j]  = lane_idx[j][EB-1:0];
            lane_a[j]   = '0;
            lane_b[j]   = '0;
            case (sew_r)
                2'd0: begin
                    lane_a[j] = {24'd0, vs2_r[{lane_el[j], 3'b000} +: 8]};
                    lane_b[j] = is_vv_r ? {24'd0, vs1_r[{lane_el[j], 3'b000} +: 8]}
                                        : {24'd0, scalar_r[7:0]};
                end
                2'd1: begin
                    lane_a[j] = {16'd0, vs2_r[{lane_el[j][EB-2:0], 4'b0000} +: 16]};
                    lane_b[j] = is_vv_r ? {16'd0, vs1_r[{lane_el[j][EB-2:0], 4'b0000} +: 16]}
                                        : {16'd0, scalar_r[15:0]};
                end
                default: begin
                    lane_a[j] = vs2_r[{lane_el[j][EB-3:0], 5'b00000} +: 32];
                    lane_b[j] = is_vv_r ? vs1_r[{lane_el[j][EB-3:0], 5'b00000} +: 32]
                                        : scalar_r;
                end
            endcase
            lane_res[j] = alu(op_r, lane_a[j], lane_b[j]);
            // eff_vl never exceeds VLMAX, so this also keeps lanes inside the register.
            lane_we[j]  = (lane_idx[j] < {1'b0, eff_vl_r}) && (vm_r || v0_r[lane_el[j]]);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            illegal   <= 1'b0;
            vd        <= '0;
            elem_i    <= '0;
            op_r      <= '0;
            sew_r     <= '0;
            is_vv_r   <= 1'b0;
            vm_r      <= 1'b0;
            v0_r      <= '0;
            scalar_r  <= '0;
            vs1_r     <= '0;
            vs2_r     <= '0;
            eff_vl_r  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_r     <= opcode;
                        sew_r    <= vsew[1:0];
                        is_vv_r  <= (op_type == 3'b001);
                        vm_r     <= vm;
                        v0_r     <= v0;
                        scalar_r <= (op_type == 3'b100) ? {{27{imm[4]}}, imm} : rs1;
                        vs1_r    <= vs1;
                        vs2_r    <= vs2;
                        eff_vl_r <= eff_vl_in;
                        vd       <= vd_old;
                        elem_i   <= '0;
                        in_ready <= 1'b0;
                        illegal  <= req_illegal;
                        if (req_illegal || (eff_vl_in == '0)) begin
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    for (int j = 0; j < LANES; j++) begin
                        if (lane_we[j]) begin
                            case (sew_r)
                                2'd0: vd[{lane_el[j], 3'b000} +: 8] <= lane_res[j][7:0];
                                2'd1: vd[{lane_el[j][EB-2:0], 4'b0000} +: 16] <= lane_res[j][15:0];
                                default: vd[{lane_el[j][EB-3:0], 5'b00000} +: 32] <= lane_res[j];
                            endcase
                        end
                    end
                    elem_i <= elem_i + IW'(LANES);
                    if ((elem_i + IW'(LANES)) >= {1'b0, eff_vl_r}) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rvv_alu_lanes.sv
// Bench for rvv_alu_lanes at VLEN=128, LANES=4: directed scenarios plus random
// requests, expected results queued at issue time and checked at output.
module tb_rvv_alu_lanes;

    localparam int VLEN  = 128;
    localparam int LANES = 4;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   opcode = '0;
    logic [2:0]   op_type = 3'b001;
    logic [2:0]   vsew = '0;
    logic [4:0]   vl = '0;
    logic         vm = 1'b1;
    logic [15:0]  v0 = '0;
    logic [31:0]  rs1 = '0;
    logic [4:0]   imm = '0;
    logic [127:0] vs1 = '0;
    logic [127:0] vs2 = '0;
    logic [127:0] vd_old = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] vd;
    logic         illegal;
    logic [1:0]   dbg_state;

    int errors = 0;
    int checks = 0;

    logic [127:0] exp_q[$];
    int           lat_q[$];
    logic         ill_q[$];

    rvv_alu_lanes #(.VLEN(VLEN), .LANES(LANES)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .op_type(op_type), .vsew(vsew), .vl(vl), .vm(vm), .v0(v0),
        .rs1(rs1), .imm(imm), .vs1(vs1), .vs2(vs2), .vd_old(vd_old),
        .out_valid(out_valid), .out_ready(out_ready), .vd(vd), .illegal(illegal),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic is_illegal(input logic [2:0] op, input logic [2:0] typ,
                                        input logic [2:0] sew);
        return (sew > 3'd2) || (op == 3'd7) || !(typ == 3'd1 || typ == 3'd2 || typ == 3'd4);
    endfunction

    function automatic int eff_vl(input logic [2:0] sew, input logic [4:0] vlv);
        int vlmax;
        vlmax = 128 / (8 << sew);
        return (int'(vlv) < vlmax) ? int'(vlv) : vlmax;
    endfunction

    function automatic int exp_latency(input logic [2:0] op, input logic [2:0] typ,
                                       input logic [2:0] sew, input logic [4:0] vlv);
        int e;
        if (is_illegal(op, typ, sew)) return 1;
        e = eff_vl(sew, vlv);
        if (e == 0) return 1;
        return (e + LANES - 1) / LANES + 1;
    endfunction

    function automatic logic [127:0] model(input logic [2:0] op, input logic [2:0] typ,
                                           input logic [2:0] sew, input logic [4:0] vlv,
                                           input logic vmv, input logic [15:0] v0v,
                                           input logic [31:0] rs1v, input logic [4:0] immv,
                                           input logic [127:0] vs1v, input logic [127:0] vs2v,
                                           input logic [127:0] vdov);
        logic [127:0] r;
        logic [31:0]  m, a, b, res;
        int           sewb, e;
        r = vdov;
        if (is_illegal(op, typ, sew)) return r;
        sewb = 8 << sew;
        e = eff_vl(sew, vlv);
        m = (sewb == 32) ? 32'hFFFF_FFFF : ((32'd1 << sewb) - 32'd1);
        for (int i = 0; i < e; i++) begin
            if (vmv || v0v[i]) begin
                a = 32'(vs2v >> (i * sewb)) & m;
                if (typ == 3'd1)      b = 32'(vs1v >> (i * sewb)) & m;
                else if (typ == 3'd2) b = rs1v & m;
                else                  b = {{27{immv[4]}}, immv} & m;
                case (op)
                    3'd0: res = a + b;
                    3'd1: res = a - b;
                    3'd2: res = a & b;
                    3'd3: res = a | b;
                    3'd4: res = a ^ b;
                    3'd5: res = (a < b) ? a : b;
                    default: res = (a > b) ? a : b;
                endcase
                res = res & m;
                r = (r & ~(128'(m) << (i * sewb))) | (128'(res) << (i * sewb));
            end
        end
        return r;
    endfunction

    task automatic push_exp(input logic [127:0] e, input int lat, input logic ill);
        exp_q.push_back(e);
        lat_q.push_back(lat);
        ill_q.push_back(ill);
    endtask

    // Drives one request and returns right after its accept edge; the inputs
    // are then scrambled so a design that fails to latch them shows it.
    task automatic send(input string name, input logic [2:0] op, input logic [2:0] typ,
                        input logic [2:0] sew, input logic [4:0] vlv, input logic vmv,
                        input logic [15:0] v0v, input logic [31:0] rs1v, input logic [4:0] immv,
                        input logic [127:0] vs1v, input logic [127:0] vs2v,
                        input logic [127:0] vdov);
        int w;
        opcode = op; op_type = typ; vsew = sew; vl = vlv; vm = vmv; v0 = v0v;
        rs1 = rs1v; imm = immv; vs1 = vs1v; vs2 = vs2v; vd_old = vdov;
        in_valid = 1'b1;
        w = 0;
        while (in_ready !== 1'b1 && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: in_ready=%b after %0d cycles, required 1", name, in_ready, w);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        opcode = 3'($urandom); op_type = 3'($urandom); vsew = 3'($urandom);
        vl = 5'($urandom); vm = 1'($urandom); v0 = 16'($urandom); rs1 = $urandom;
        imm = 5'($urandom); vs1 = rnd128(); vs2 = rnd128(); vd_old = rnd128();
    endtask

    // Pops the oldest expectation, waits for out_valid, checks it, optionally
    // stalls for `stall` cycles, then completes the output handshake.
    task automatic collect(input string name, input int stall);
        logic [127:0] e;
        int           el, lat;
        logic         ei;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: queue empty, required an entry", name);
            return;
        end
        e = exp_q.pop_front(); el = lat_q.pop_front(); ei = ill_q.pop_front();
        lat = 1;
        while (out_valid !== 1'b1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: out_valid=%b after %0d cycles, required 1", name, out_valid, lat);
        end
        checks++;
        if (lat != el) begin
            errors++;
            $display("FAIL %s latency: got %0d, required %0d", name, lat, el);
        end
        checks++;
        if (vd !== e) begin
            errors++;
            $display("FAIL %s vd: got %h, required %h", name, vd, e);
        end
        checks++;
        if (illegal !== ei) begin
            errors++;
            $display("FAIL %s illegal: got %b, required %b", name, illegal, ei);
        end
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || vd !== e || illegal !== ei) begin
                errors++;
                $display("FAIL %s stall%0d: out_valid=%b in_ready=%b vd=%h, required 1 0 %h",
                         name, k, out_valid, in_ready, vd, e);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s release: out_valid=%b in_ready=%b, required 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || illegal !== 1'b0 || vd !== '0 ||
            dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b illegal=%b vd=%h state=%0d, required 1 0 0 0 0",
                     in_ready, out_valid, illegal, vd, dbg_state);
        end
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_vadd_vv();
        logic [127:0] a, b, e, old;
        for (int i = 0; i < 16; i++) begin
            a[i*8 +: 8] = 8'(i);
            b[i*8 +: 8] = 8'h10;
            e[i*8 +: 8] = 8'h10 + 8'(i);
        end
        old = rnd128();
        push_exp(e, 5, 1'b0);
        send("vadd_vv", 3'd0, 3'b001, 3'd0, 5'd16, 1'b1, 16'h0, 32'h0, 5'h0, a, b, old);
        collect("vadd_vv", 0);
    endtask

    task automatic test_vsub_vx_tail();
        logic [127:0] b, old, e;
        b   = {32'd9, 32'd7, 32'd5, 32'd0};
        old = {4{32'hAAAA_AAAA}};
        e   = {32'hAAAA_AAAA, 32'd6, 32'd4, 32'hFFFF_FFFF};
        push_exp(e, 2, 1'b0);
        send("vsub_vx", 3'd1, 3'b010, 3'd2, 5'd3, 1'b1, 16'h0, 32'd1, 5'h0, rnd128(), b, old);
        collect("vsub_vx", 0);
    endtask

    task automatic test_masked_vand_vi();
        logic [127:0] b, e;
        b = {8{16'h1234}};
        e = {4{16'h0000, 16'h0004}};
        push_exp(e, 3, 1'b0);
        send("vand_vi_mask", 3'd2, 3'b100, 3'd1, 5'd8, 1'b0, 16'h0055, 32'h0, 5'h0F,
             rnd128(), b, 128'h0);
        collect("vand_vi_mask", 0);
    endtask

    task automatic test_vl_bounds();
        logic [127:0] a, b, old;
        a = rnd128(); b = rnd128(); old = rnd128();
        push_exp(old, 1, 1'b0);
        send("vl0", 3'd0, 3'b001, 3'd0, 5'd0, 1'b1, 16'h0, 32'h0, 5'h0, a, b, old);
        collect("vl0", 0);
        a = rnd128(); b = rnd128(); old = rnd128();
        push_exp(a | b, 3, 1'b0);
        send("vl20_sew16", 3'd3, 3'b001, 3'd1, 5'd20, 1'b1, 16'h0, 32'h0, 5'h0, a, b, old);
        collect("vl20_sew16", 0);
    endtask

    task automatic test_illegal();
        logic [127:0] a, b, old;
        old = rnd128();
        push_exp(old, 1, 1'b1);
        send("ill_sew3", 3'd0, 3'b001, 3'd3, 5'd16, 1'b1, 16'h0, 32'h0, 5'h0, rnd128(), rnd128(), old);
        collect("ill_sew3", 0);
        old = rnd128();
        push_exp(old, 1, 1'b1);
        send("ill_op7", 3'd7, 3'b001, 3'd0, 5'd16, 1'b1, 16'h0, 32'h0, 5'h0, rnd128(), rnd128(), old);
        collect("ill_op7", 0);
        old = rnd128();
        push_exp(old, 1, 1'b1);
        send("ill_type", 3'd0, 3'b011, 3'd0, 5'd16, 1'b1, 16'h0, 32'h0, 5'h0, rnd128(), rnd128(), old);
        collect("ill_type", 0);
        a = rnd128(); b = rnd128();
        push_exp(a ^ b, 5, 1'b0);
        send("after_ill", 3'd4, 3'b001, 3'd0, 5'd16, 1'b1, 16'h0, 32'h0, 5'h0, a, b, rnd128());
        collect("after_ill", 0);
    endtask

    task automatic test_back_pressure();
        logic [127:0] a, b, old;
        a = rnd128(); b = rnd128(); old = rnd128();
        push_exp(model(3'd6, 3'b001, 3'd0, 5'd16, 1'b1, 16'h0, 32'h0, 5'h0, a, b, old), 5, 1'b0);
        send("maxu_stall", 3'd6, 3'b001, 3'd0, 5'd16, 1'b1, 16'h0, 32'h0, 5'h0, a, b, old);
        collect("maxu_stall", 3);
    endtask

    task automatic test_back_to_back();
        logic [127:0] a, b, old;
        for (int n = 0; n < 3; n++) begin
            a = rnd128(); b = rnd128(); old = rnd128();
            push_exp(model(3'd5, 3'b010, 3'd1, 5'd8, 1'b1, 16'h0, 32'h0000_8001, 5'h0, a, b, old),
                     3, 1'b0);
            send("b2b_minu_vx", 3'd5, 3'b010, 3'd1, 5'd8, 1'b1, 16'h0, 32'h0000_8001, 5'h0, a, b, old);
            collect("b2b_minu_vx", 0);
        end
    endtask

    task automatic test_random();
        logic [2:0]   op, typ, sew;
        logic [4:0]   vlv, immv;
        logic         vmv;
        logic [15:0]  v0v;
        logic [31:0]  rs1v;
        logic [127:0] a, b, old;
        logic [2:0]   types [4];
        types[0] = 3'b001; types[1] = 3'b010; types[2] = 3'b100; types[3] = 3'b110;
        for (int n = 0; n < 30; n++) begin
            op   = 3'($urandom_range(0, 7));
            typ  = types[$urandom_range(0, 3)];
            sew  = 3'($urandom_range(0, 3));
            vlv  = 5'($urandom_range(0, 31));
            vmv  = 1'($urandom_range(0, 1));
            v0v  = 16'($urandom);
            rs1v = $urandom;
            immv = 5'($urandom);
            a = rnd128(); b = rnd128(); old = rnd128();
            push_exp(model(op, typ, sew, vlv, vmv, v0v, rs1v, immv, a, b, old),
                     exp_latency(op, typ, sew, vlv), is_illegal(op, typ, sew));
            send("random", op, typ, sew, vlv, vmv, v0v, rs1v, immv, a, b, old);
            collect("random", $urandom_range(0, 2));
        end
    endtask

    task automatic test_reset_mid_run();
        logic [127:0] a, b;
        a = rnd128(); b = rnd128();
        send("rst_run", 3'd0, 3'b001, 3'd0, 5'd16, 1'b1, 16'h0, 32'h0, 5'h0, a, b, rnd128());
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || vd !== '0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL rst_run: in_ready=%b out_valid=%b vd=%h state=%0d, required 1 0 0 0",
                     in_ready, out_valid, vd, dbg_state);
        end
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_run_quiet%0d: out_valid=%b, required 0", k, out_valid);
            end
        end
        a = rnd128(); b = rnd128();
        push_exp(a & b, 5, 1'b0);
        send("after_rst", 3'd2, 3'b001, 3'd0, 5'd16, 1'b1, 16'h0, 32'h0, 5'h0, a, b, rnd128());
        collect("after_rst", 0);
    endtask

    initial begin
        test_reset();
        test_vadd_vv();
        test_vsub_vx_tail();
        test_masked_vand_vi();
        test_vl_bounds();
        test_illegal();
        test_back_pressure();
        test_back_to_back();
        test_random();
        test_reset_mid_run();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
